acx_axil_reg_master: RTL

- AXI4-Lite target to register-bus initiator bridge.
- Converts single AXI4-Lite reads and writes into held strobe/address/data accesses on the shared 32-bit configuration register bus.
- Waits for the OR-reduced address-hit from the register slaves and returns the AXI response.
- A timeout completes accesses to unmapped addresses with SLVERR.

---
 rtl/acx_axil_reg_master.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/acx_axil_reg_master.sv
`timescale 1ns/1ps
// acx_axil_reg_master
// AXI4-Lite target that turns single reads/writes into held accesses on the
// shared configuration register bus. Strobes, address and write data are held
// until the OR-reduced slave hit arrives or a timeout expires (SLVERR).
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_aw*/o_awready, i_w*/o_wready    AXI write address / write data channels
//   o_bresp/o_bvalid/i_bready         AXI write response channel
//   i_ar*/o_arready                   AXI read address channel
//   o_rdata/o_rresp/o_rvalid/i_rready AXI read data channel
//   o_reg_wr/o_reg_rd                 register bus byte write strobes / read strobe
//   o_reg_addr/o_reg_wdata            register bus address / write data
//   i_reg_addr_hit/i_reg_rdata        OR of slave hits / muxed slave read data
module acx_axil_reg_master #(
    parameter int TGT_ADDR_WIDTH = 28,
    parameter int TGT_DATA_WIDTH = 32,
    parameter int TIMEOUT = 255,
    parameter logic [TGT_DATA_WIDTH-1:0] ERR_DATA = 32'hDEADDEAD
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [TGT_ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                        i_awvalid,
    output logic                        o_awready,
    input  logic [TGT_DATA_WIDTH-1:0]   i_wdata,
    input  logic [TGT_DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                        i_wvalid,
    output logic                        o_wready,
    output logic [1:0]                  o_bresp,
    output logic                        o_bvalid,
    input  logic                        i_bready,
    input  logic [TGT_ADDR_WIDTH-1:0]   i_araddr,
    input  logic                        i_arvalid,
    output logic                        o_arready,
    output logic [TGT_DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]                  o_rresp,
    output logic                        o_rvalid,
    input  logic                        i_rready,
    output logic [TGT_DATA_WIDTH/8-1:0] o_reg_wr,
    output logic                        o_reg_rd,
    output logic [TGT_ADDR_WIDTH-1:0]   o_reg_addr,
    output logic [TGT_DATA_WIDTH-1:0]   o_reg_wdata,
    input  logic                        i_reg_addr_hit,
    input  logic [TGT_DATA_WIDTH-1:0]   i_reg_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int SW = TGT_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                    state_r;
    logic                      aw_cap_r, w_cap_r;
    logic [TGT_ADDR_WIDTH-1:0] awaddr_r;
    logic [TGT_DATA_WIDTH-1:0] wdata_r;
    logic [SW-1:0]             wstrb_r;
    logic                      last_rd_r;   // 1: the most recently served access was a read
    logic                      is_rd_r;
    logic                      drain_r;
    logic [CW-1:0]             cnt_r;
    logic                      awready_r, wready_r, arready_r;
    logic                      bvalid_r, rvalid_r;
    logic [1:0]                bresp_r, rresp_r;
    logic [TGT_DATA_WIDTH-1:0] rdata_r;
    logic [SW-1:0]             reg_wr_r;
    logic                      reg_rd_r;
    logic [TGT_ADDR_WIDTH-1:0] reg_addr_r;
    logic [TGT_DATA_WIDTH-1:0] reg_wdata_r;

    logic aw_hs_s, w_hs_s, ar_hs_s;
    logic wr_go_s, rd_go_s, serve_wr_s, serve_rd_s;
    logic aw_cap_nxt_s, w_cap_nxt_s, idle_nxt_s;

    // Handshakes, start arbitration and next-cycle capture/IDLE decisions.
    always_comb begin
        aw_hs_s = i_awvalid && awready_r;
        w_hs_s  = i_wvalid && wready_r;
        ar_hs_s = i_arvalid && arready_r;
        // A write starts only from fully captured AW+W; arready is low while
        // anything is captured, so simultaneous AW/W/AR serve the read first.
        wr_go_s = (state_r == IDLE) && aw_cap_r && w_cap_r;
        rd_go_s = (state_r == IDLE) && ar_hs_s;
        serve_wr_s = wr_go_s && (!rd_go_s || last_rd_r);
        serve_rd_s = rd_go_s && (!wr_go_s || !last_rd_r);
        if (serve_wr_s) begin
            aw_cap_nxt_s = 1'b0;
            w_cap_nxt_s  = 1'b0;
        end else begin
            aw_cap_nxt_s = aw_cap_r || aw_hs_s;
            w_cap_nxt_s  = w_cap_r || w_hs_s;
        end
        case (state_r)
            IDLE:    idle_nxt_s = !(serve_wr_s || serve_rd_s);
            DRAIN:   idle_nxt_s = drain_r;
            default: idle_nxt_s = 1'b0;
        endcase
    end

    // Main FSM: channel capture, register-bus access, response and drain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= IDLE;
            aw_cap_r    <= 1'b0;
            w_cap_r     <= 1'b0;
            awaddr_r    <= '0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            last_rd_r   <= 1'b1;
            is_rd_r     <= 1'b0;
            drain_r     <= 1'b0;
            cnt_r       <= '0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            arready_r   <= 1'b0;
            bvalid_r    <= 1'b0;
            rvalid_r    <= 1'b0;
            bresp_r     <= RESP_OKAY;
            rresp_r     <= RESP_OKAY;
            rdata_r     <= '0;
            reg_wr_r    <= '0;
            reg_rd_r    <= 1'b0;
            reg_addr_r  <= '0;
            reg_wdata_r <= '0;
        end else begin
            aw_cap_r  <= aw_cap_nxt_s;
            w_cap_r   <= w_cap_nxt_s;
            awready_r <= idle_nxt_s && !aw_cap_nxt_s;
            wready_r  <= idle_nxt_s && !w_cap_nxt_s;
            arready_r <= idle_nxt_s && !aw_cap_nxt_s && !w_cap_nxt_s;
            if (aw_hs_s) begin
                awaddr_r <= i_awaddr;
            end
            if (w_hs_s) begin
                wdata_r <= i_wdata;
                wstrb_r <= i_wstrb;
            end
            case (state_r)
                IDLE: begin
                    if (serve_wr_s) begin
                        last_rd_r <= 1'b0;
                        is_rd_r   <= 1'b0;
                        if (wstrb_r == {SW{1'b0}}) begin
                            // Nothing to write: answer OKAY without touching the bus.
                            bvalid_r <= 1'b1;
                            bresp_r  <= RESP_OKAY;
                            state_r  <= RESP;
                        end else begin
                            reg_addr_r  <= awaddr_r;
                            reg_wdata_r <= wdata_r;
                            reg_wr_r    <= wstrb_r;
                            cnt_r       <= '0;
                            state_r     <= ACCESS;
                        end
                    end else if (serve_rd_s) begin
                        last_rd_r  <= 1'b1;
                        is_rd_r    <= 1'b1;
                        reg_addr_r <= i_araddr;
                        reg_rd_r   <= 1'b1;
                        cnt_r      <= '0;
                        state_r    <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (i_reg_addr_hit) begin
                        reg_wr_r <= '0;
                        reg_rd_r <= 1'b0;
                        state_r  <= RESP;
                        if (is_rd_r) begin
                            rdata_r  <= i_reg_rdata;
                            rresp_r  <= RESP_OKAY;
                            rvalid_r <= 1'b1;
                        end else begin
                            bresp_r  <= RESP_OKAY;
                            bvalid_r <= 1'b1;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        reg_wr_r <= '0;
                        reg_rd_r <= 1'b0;
                        state_r  <= RESP;
                        if (is_rd_r) begin
                            rdata_r  <= ERR_DATA;
                            rresp_r  <= RESP_SLVERR;
                            rvalid_r <= 1'b1;
                        end else begin
                            bresp_r  <= RESP_SLVERR;
                            bvalid_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RESP: begin
                    if ((bvalid_r && i_bready) || (rvalid_r && i_rready)) begin
                        bvalid_r <= 1'b0;
                        rvalid_r <= 1'b0;
                        drain_r  <= 1'b0;
                        state_r  <= DRAIN;
                    end else begin
                        state_r <= RESP;
                    end
                end
                DRAIN: begin
                    // Two strobe-free cycles let a slave's registered hit clear.
                    if (drain_r) begin
                        state_r <= IDLE;
                    end else begin
                        drain_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_awready   = awready_r;
    assign o_wready    = wready_r;
    assign o_arready   = arready_r;
    assign o_bvalid    = bvalid_r;
    assign o_bresp     = bresp_r;
    assign o_rvalid    = rvalid_r;
    assign o_rresp     = rresp_r;
    assign o_rdata     = rdata_r;
    assign o_reg_wr    = reg_wr_r;
    assign o_reg_rd    = reg_rd_r;
    assign o_reg_addr  = reg_addr_r;
    assign o_reg_wdata = reg_wdata_r;

endmodule
